mem_stage_dcache: RTL and testbench

//  Consumer end of the EX/MEM pipeline register: MEM-stage data cache controller. Takes the

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/dcache_array.sv | 49 ++++
 rtl/mem_stage_dcache.sv | 126 ++++++++++++
 tb/tb_mem_stage_dcache.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and geometry constants for the MEM-stage data cache.
// The address splits into byte offset, line index and tag, from the LSB upwards.
package mem_stage_pkg;
   localparam int INDEX_BITS_DEF = 4;
   localparam int ADDR_W_DEF     = 64;
   localparam int DATA_W_DEF     = 64;
   localparam int OFFSET_W       = 3;
   localparam int TAG_W_DEF      = ADDR_W_DEF - INDEX_BITS_DEF - OFFSET_W;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      FILL,
      WR_REQ,
      WR_DONE
   } state_t;

   function automatic int tag_width(input int addr_w, input int index_bits);
      return addr_w - index_bits - OFFSET_W;
   endfunction
endpackage

// File: rtl/dcache_array.sv
// Direct-mapped line storage: one valid bit, tag and data word per line.
// Lookup is combinational. Only the valid bits are reset, which invalidates every line.
module dcache_array
   import mem_stage_pkg::*;
#(
   parameter int INDEX_BITS = INDEX_BITS_DEF,
   parameter int TAG_W      = TAG_W_DEF,
   parameter int DATA_W     = DATA_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_W-1:0]      rd_tag,
   output logic [DATA_W-1:0]     rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [DATA_W-1:0]     wr_data
);
   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]  valid_reg;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES];

   genvar gi;
   generate
      for (gi = 0; gi < LINES; gi++) begin : g_valid
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               valid_reg[gi] <= 1'b0;
            else if (wr_en && wr_index == gi[INDEX_BITS-1:0])
               valid_reg[gi] <= 1'b1;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid_reg[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index];
endmodule

// File: rtl/mem_stage_dcache.sv
// MEM-stage controller: serves loads from a write-through direct-mapped cache.
// hit=0 freezes the pipeline while a miss or store is in flight to backing memory.
module mem_stage_dcache
   import mem_stage_pkg::*;
#(
   parameter int INDEX_BITS = INDEX_BITS_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic              branch,
   input  logic              zero_flag,
   output logic [DATA_W-1:0] read_data,
   output logic              hit,
   output logic              pc_src,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);
   localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS);

   state_t                  state_reg, state_next;
   logic [DATA_W-1:0]       fill_data_reg;
   logic [INDEX_BITS-1:0]   index;
   logic [TAG_W-1:0]        tag;
   logic                    rd_valid;
   logic [TAG_W-1:0]        rd_tag;
   logic [DATA_W-1:0]       rd_data;
   logic                    lookup_hit;
   logic                    wr_en;
   logic [DATA_W-1:0]       wr_data;

   assign index      = addr[OFFSET_W +: INDEX_BITS];
   assign tag        = addr[ADDR_W-1 -: TAG_W];
   assign lookup_hit = rd_valid && (rd_tag == tag);

   dcache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_W      (TAG_W),
      .DATA_W     (DATA_W)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_index (index),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_index (index),
      .wr_tag   (tag),
      .wr_data  (wr_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         fill_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == RD_REQ && mem_ack)
            fill_data_reg <= mem_rdata;
      end
   end

   // Stores win over loads; a store updates the cache only if the line already holds it.
   always_comb begin
      state_next = state_reg;
      hit        = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      wr_en      = 1'b0;
      wr_data    = write_data;
      read_data  = '0;
      case (state_reg)
         IDLE: begin
            if (mem_write) begin
               state_next = WR_REQ;
            end else if (mem_read) begin
               if (lookup_hit) begin
                  hit       = 1'b1;
                  read_data = rd_data;
               end else begin
                  state_next = RD_REQ;
               end
            end else begin
               hit = 1'b1;
            end
         end
         RD_REQ: begin
            mem_req = 1'b1;
            if (mem_ack)
               state_next = FILL;
         end
         FILL: begin
            wr_en      = 1'b1;
            wr_data    = fill_data_reg;
            state_next = IDLE;
         end
         WR_REQ: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack) begin
               wr_en      = lookup_hit;
               state_next = WR_DONE;
            end
         end
         WR_DONE: begin
            hit        = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign pc_src    = branch & zero_flag;
   assign mem_addr  = addr & ~{{(ADDR_W-OFFSET_W){1'b0}}, {OFFSET_W{1'b1}}};
   assign mem_wdata = write_data;
endmodule

// File: tb/tb_mem_stage_dcache.sv
// Directed bench for mem_stage_dcache: a small backing-memory responder acks requests
// after a chosen number of request cycles; each scenario task checks its own results.
module tb_mem_stage_dcache;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write;
   logic [63:0] addr, write_data;
   logic        branch, zero_flag;
   logic [63:0] read_data;
   logic        hit, pc_src, mem_req, mem_we;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;

   int total = 0;
   int bad   = 0;

   int          st;      // hit=0 cycles observed for the access
   int          rq;      // cycles with mem_req=1
   logic [63:0] rd_v;    // read_data when hit rose
   logic        we_v;
   logic [63:0] ad_v, wd_v;

   mem_stage_dcache dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .addr       (addr),
      .write_data (write_data),
      .branch     (branch),
      .zero_flag  (zero_flag),
      .read_data  (read_data),
      .hit        (hit),
      .pc_src     (pc_src),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   always #5 clk = ~clk;

   // Called just after a posedge; returns just after the posedge that retires the access.
   task run_access(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] wd,
                   input int ack_after, input logic [63:0] rvalue);
      int  wait_n;
      logic done;
      mem_read = rd; mem_write = wr; addr = a; write_data = wd;
      st = 0; rq = 0; wait_n = 0; done = 1'b0;
      rd_v = '0; we_v = 1'b0; ad_v = '0; wd_v = '0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (hit) begin
            rd_v = read_data;
            done = 1'b1;
            break;
         end
         st++;
         if (mem_req) begin
            rq++;
            we_v = mem_we; ad_v = mem_addr; wd_v = mem_wdata;
            wait_n++;
            if (wait_n == ack_after) begin
               mem_ack = 1'b1;
               mem_rdata = rvalue;
            end
         end
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL access_timeout addr=%h: hit never rose, required within 60 cycles", a);
      end
      $display("access rd=%0b wr=%0b addr=%h stalls=%0d reqs=%0d we=%0b data=%h", rd, wr, a, st, rq, we_v, rd_v);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task test_reset;
      int guard;
      #2;
      total++; if (hit !== 1'b1) begin bad++; $display("FAIL rst_hit got=%b want=1", hit); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", mem_we); end
      total++; if (read_data !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", read_data); end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      run_access(1'b1, 1'b0, 64'h100, 64'h0, 1, 64'h1111);
      total++; if (rd_v !== 64'h1111) begin bad++; $display("FAIL rst_fill got=%h want=1111", rd_v); end
      // load a different tag, then reset while its read request is pending
      mem_read = 1'b1; addr = 64'h200;
      guard = 0;
      do begin
         @(negedge clk); guard++;
      end while (!mem_req && guard < 10);
      rst_n = 1'b0; #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mid_req got=%b want=0", mem_req); end
      mem_read = 1'b0; #1;
      total++; if (hit !== 1'b1) begin bad++; $display("FAIL rst_mid_hit got=%b want=1", hit); end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      run_access(1'b1, 1'b0, 64'h100, 64'h0, 1, 64'h2222);
      total++; if (rq !== 1) begin bad++; $display("FAIL rst_after_miss reqs got=%0d want=1", rq); end
      total++; if (rd_v !== 64'h2222) begin bad++; $display("FAIL rst_after_data got=%h want=2222", rd_v); end
   endtask

   task test_load_miss_hit;
      run_access(1'b1, 1'b0, 64'h40, 64'h0, 3, 64'hDEAD);
      total++; if (st !== 5) begin bad++; $display("FAIL miss_stalls got=%0d want=5", st); end
      total++; if (rq !== 3) begin bad++; $display("FAIL miss_reqs got=%0d want=3", rq); end
      total++; if (we_v !== 1'b0) begin bad++; $display("FAIL miss_we got=%b want=0", we_v); end
      total++; if (ad_v !== 64'h40) begin bad++; $display("FAIL miss_addr got=%h want=40", ad_v); end
      total++; if (rd_v !== 64'hDEAD) begin bad++; $display("FAIL miss_data got=%h want=dead", rd_v); end
      run_access(1'b1, 1'b0, 64'h44, 64'h0, 1, 64'hBAD0);
      total++; if (st !== 0) begin bad++; $display("FAIL hit_stalls got=%0d want=0", st); end
      total++; if (rq !== 0) begin bad++; $display("FAIL hit_reqs got=%0d want=0", rq); end
      total++; if (rd_v !== 64'hDEAD) begin bad++; $display("FAIL hit_data got=%h want=dead", rd_v); end
   endtask

   task test_store_hit;
      run_access(1'b0, 1'b1, 64'h40, 64'h1234, 1, 64'h0);
      total++; if (st !== 2) begin bad++; $display("FAIL st_stalls got=%0d want=2", st); end
      total++; if (rq !== 1) begin bad++; $display("FAIL st_reqs got=%0d want=1", rq); end
      total++; if (we_v !== 1'b1) begin bad++; $display("FAIL st_we got=%b want=1", we_v); end
      total++; if (ad_v !== 64'h40) begin bad++; $display("FAIL st_addr got=%h want=40", ad_v); end
      total++; if (wd_v !== 64'h1234) begin bad++; $display("FAIL st_wdata got=%h want=1234", wd_v); end
      // the store must not be reissued once it has retired
      @(negedge clk);
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL st_no_reissue got=%b want=0", mem_req); end
      @(posedge clk); #1;
      run_access(1'b1, 1'b0, 64'h40, 64'h0, 1, 64'hBAD1);
      total++; if (rq !== 0) begin bad++; $display("FAIL st_load_reqs got=%0d want=0", rq); end
      total++; if (rd_v !== 64'h1234) begin bad++; $display("FAIL st_load_data got=%h want=1234", rd_v); end
   endtask

   task test_store_miss;
      run_access(1'b0, 1'b1, 64'h80, 64'h7777, 2, 64'h0);
      total++; if (st !== 3) begin bad++; $display("FAIL stm_stalls got=%0d want=3", st); end
      total++; if (ad_v !== 64'h80) begin bad++; $display("FAIL stm_addr got=%h want=80", ad_v); end
      run_access(1'b1, 1'b0, 64'h80, 64'h0, 1, 64'h5555);
      total++; if (rq !== 1) begin bad++; $display("FAIL stm_load_reqs got=%0d want=1", rq); end
      total++; if (rd_v !== 64'h5555) begin bad++; $display("FAIL stm_load_data got=%h want=5555", rd_v); end
   endtask

   task test_alias;
      run_access(1'b1, 1'b0, 64'h40, 64'h0, 1, 64'hBAD2);
      total++; if (rq !== 0) begin bad++; $display("FAIL al_first_reqs got=%0d want=0", rq); end
      run_access(1'b1, 1'b0, 64'hC0, 64'h0, 1, 64'hC0C0);
      total++; if (st !== 3) begin bad++; $display("FAIL al_evict_stalls got=%0d want=3", st); end
      total++; if (rd_v !== 64'hC0C0) begin bad++; $display("FAIL al_evict_data got=%h want=c0c0", rd_v); end
      run_access(1'b1, 1'b0, 64'h40, 64'h0, 1, 64'h4040);
      total++; if (rq !== 1) begin bad++; $display("FAIL al_back_reqs got=%0d want=1", rq); end
      total++; if (rd_v !== 64'h4040) begin bad++; $display("FAIL al_back_data got=%h want=4040", rd_v); end
   endtask

   task test_priority_branch;
      logic [1:0] bz;
      run_access(1'b1, 1'b1, 64'h4D, 64'hABCD, 1, 64'hBAD3);
      total++; if (we_v !== 1'b1) begin bad++; $display("FAIL prio_we got=%b want=1", we_v); end
      total++; if (ad_v !== 64'h48) begin bad++; $display("FAIL prio_addr got=%h want=48", ad_v); end
      total++; if (wd_v !== 64'hABCD) begin bad++; $display("FAIL prio_wdata got=%h want=abcd", wd_v); end
      for (int i = 0; i < 4; i++) begin
         bz = i[1:0];
         branch = bz[1]; zero_flag = bz[0]; #1;
         total++;
         if (pc_src !== (i == 3)) begin
            bad++;
            $display("FAIL pc_src b=%b z=%b got=%b want=%b", bz[1], bz[0], pc_src, (i == 3));
         end
      end
      branch = 1'b0; zero_flag = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; write_data = '0;
      branch = 1'b0; zero_flag = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
      test_reset;
      test_load_miss_hit;
      test_store_hit;
      test_store_miss;
      test_alias;
      test_priority_branch;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
